// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing and colour stream bundle
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_text_box.sv
// rtl/draw_text_box.sv - character grid overlay with frame-synchronous control and blinking cursor
module draw_text_box #(
    parameter logic [10:0] X_POS        = 11'd0,
    parameter logic [10:0] Y_POS        = 11'd0,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 16,
    parameter int          CHAR_W       = 8,
    parameter int          CHAR_H       = 16,
    parameter logic [11:0] FG_DEFAULT   = 12'h064,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 32,
    localparam int CW  = $clog2(COLS),
    localparam int RW  = $clog2(ROWS),
    localparam int XS  = $clog2(CHAR_W),
    localparam int YS  = $clog2(CHAR_H),
    localparam int PXW = (XS > 0) ? XS : 1,
    localparam int LW  = (YS > 0) ? YS : 1
) (
    input  logic              clk65MHz,
    input  logic              rst,
    vga_if.slave              vga_in,
    vga_if.master             vga_out,
    input  logic [11:0]       fg_color,
    input  logic              text_en,
    input  logic              opaque,
    input  logic              cursor_en,
    input  logic [CW-1:0]     cursor_col,
    input  logic [RW-1:0]     cursor_row,
    output logic [RW+CW-1:0]  char_xy,
    output logic [LW-1:0]     char_line,
    input  logic [CHAR_W-1:0] char_pixel
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [11:0] BOX_W = 12'(COLS * CHAR_W);
    localparam logic [11:0] BOX_H = 12'(ROWS * CHAR_H);

    logic [11:0] dx_full, dy_full;
    logic [10:0] dx, dy;
    logic        in_box;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [LW-1:0]  line;
    logic [PXW-1:0] px;

    logic [11:0] fg_q;
    logic        text_en_q, opaque_q, cursor_en_q;
    logic [CW-1:0] cursor_col_q;
    logic [RW-1:0] cursor_row_q;
    logic          vsync_prev, vs_rise, blink_on;
    logic [FW-1:0] frame_cnt;

    logic [PXW-1:0] px_d1;
    logic           in_box_d1, hit_d1;
    logic [10:0]    hcount_d1, vcount_d1;
    logic           hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
    logic [11:0]    rgb_d1, rgb_nxt;
    logic [CHAR_W-1:0] glyph_row;
    logic           lit;

    // The borrow bit of the widened subtraction is the hcount < X_POS test,
    // so pixels left of / above the box never wrap into it.
    always_comb begin
        dx_full = {1'b0, vga_in.hcount} - {1'b0, X_POS};
        dy_full = {1'b0, vga_in.vcount} - {1'b0, Y_POS};
        dx      = dx_full[10:0];
        dy      = dy_full[10:0];
        in_box  = !dx_full[11] && ({1'b0, dx} < BOX_W) &&
                  !dy_full[11] && ({1'b0, dy} < BOX_H);
        col     = CW'(dx >> XS);
        row     = RW'(dy >> YS);
        line    = LW'(dy & 11'(CHAR_H - 1));
        px      = PXW'(dx & 11'(CHAR_W - 1));
    end

    assign vs_rise = vga_in.vsync && !vsync_prev;

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            vsync_prev   <= 1'b0;
            fg_q         <= FG_DEFAULT;
            text_en_q    <= 1'b0;
            opaque_q     <= 1'b0;
            cursor_en_q  <= 1'b0;
            cursor_col_q <= '0;
            cursor_row_q <= '0;
            frame_cnt    <= '0;
            blink_on     <= 1'b1;
        end else begin
            vsync_prev <= vga_in.vsync;
            if (vs_rise) begin
                fg_q         <= fg_color;
                text_en_q    <= text_en;
                opaque_q     <= opaque;
                cursor_en_q  <= cursor_en;
                cursor_col_q <= cursor_col;
                cursor_row_q <= cursor_row;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Cycle 1: present the cell address to the glyph memory and delay the stream.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            char_xy   <= '0;
            char_line <= '0;
            px_d1     <= '0;
            in_box_d1 <= 1'b0;
            hit_d1    <= 1'b0;
            hcount_d1 <= '0;
            vcount_d1 <= '0;
            hsync_d1  <= 1'b0;
            vsync_d1  <= 1'b0;
            hblnk_d1  <= 1'b0;
            vblnk_d1  <= 1'b0;
            rgb_d1    <= '0;
        end else begin
            char_xy   <= in_box ? {row, col} : '0;
            char_line <= in_box ? line : '0;
            px_d1     <= px;
            in_box_d1 <= in_box;
            hit_d1    <= (row == cursor_row_q) && (col == cursor_col_q);
            hcount_d1 <= vga_in.hcount;
            vcount_d1 <= vga_in.vcount;
            hsync_d1  <= vga_in.hsync;
            vsync_d1  <= vga_in.vsync;
            hblnk_d1  <= vga_in.hblnk;
            vblnk_d1  <= vga_in.vblnk;
            rgb_d1    <= vga_in.rgb;
        end
    end

    always_comb begin
        glyph_row = char_pixel << px_d1;
        lit       = glyph_row[CHAR_W-1] ^ (cursor_en_q && hit_d1 && blink_on);
        if (hblnk_d1 || vblnk_d1)
            rgb_nxt = '0;
        else if (!text_en_q || !in_box_d1)
            rgb_nxt = rgb_d1;
        else if (lit)
            rgb_nxt = fg_q;
        else if (opaque_q)
            rgb_nxt = BG_COLOR;
        else
            rgb_nxt = rgb_d1;
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= hcount_d1;
            vga_out.vcount <= vcount_d1;
            vga_out.hsync  <= hsync_d1;
            vga_out.vsync  <= vsync_d1;
            vga_out.hblnk  <= hblnk_d1;
            vga_out.vblnk  <= vblnk_d1;
            vga_out.rgb    <= rgb_nxt;
        end
    end

endmodule
